// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage pipeline.
// Resolves RAW hazards by forwarding where possible, stalls on load-use and
// branch-compare dependencies, and sequences a halt: once a halt instruction
// is accepted the front end is frozen for DRAIN_CYCLES cycles while older
// instructions retire, then the pipeline stays halted until reset.
//
// Handshake: there is no valid/ready flow here; every output is a per-cycle
// control level. StallF/StallD/FlushE are asserted together, and FlushD is
// never asserted in a cycle where decode is stalled.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             HaltD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             Draining,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q;
    logic [DCW-1:0]   drain_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lwstall;
    logic branchstall;
    logic hazard;
    logic in_run;
    logic halt_take;

    // Execute-stage operand forwarding; the youngest producer (M) wins over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)      ForwardAE = 2'b10;
        else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) ForwardAE = 2'b01;
        if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)      ForwardBE = 2'b10;
        else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) ForwardBE = 2'b01;
    end

    // Decode-stage comparator forwarding from the M-stage result.
    always_comb begin
        ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
        ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
    end

    // Hazard detection and front-end control; outside RUN the front end is frozen.
    always_comb begin
        lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        branchstall = BranchD &&
                      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
        hazard      = lwstall || branchstall;
        in_run      = (state_q == RUN);
        StallF      = in_run ? hazard : 1'b1;
        StallD      = StallF;
        FlushE      = StallF;
        FlushD      = in_run && (PCSrcD || JumpD) && !hazard;
        // A stalled halt simply waits; it is accepted on its first unstalled cycle.
        halt_take   = in_run && HaltD && !BranchD && !JumpD && !hazard;
        Draining    = (state_q == DRAIN);
        Halted      = (state_q == HALTED);
    end

    // Halt sequencer: RUN -> DRAIN (DRAIN_CYCLES cycles) -> HALTED until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_take) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q <= HALTED;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DCW'(1);
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q     <= RUN;
                    drain_cnt_q <= '0;
                end
            endcase
        end
    end

    // Saturating count of hazard stall cycles seen while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (in_run && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a default-width instance and a
// 4-bit-counter instance share stimulus; a behavioural model tracks the halt
// as "edges since the halt was accepted" and counts stalls with plain integers.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, PCSrcD, JumpD, HaltD;

  logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, Draining, Halted;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  logic s_StallF, s_StallD, s_FlushD, s_FlushE, s_ForwardAD, s_ForwardBD, s_Draining, s_Halted;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [3:0] s_StallCount;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD), .HaltD(HaltD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .Draining(Draining), .Halted(Halted), .StallCount(StallCount)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD), .HaltD(HaltD),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .Draining(s_Draining), .Halted(s_Halted), .StallCount(s_StallCount)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age_m < 0: running; 1..DRAIN: draining; > DRAIN: halted.
  int age_m = -1;
  int c16_m = 0;
  int c4_m  = 0;

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (r != 0 && RegWriteM && WriteRegM == r) return 2'b10;
    if (r != 0 && RegWriteW && WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic fwd_d(input logic [4:0] r);
    return (r != 0) && RegWriteM && (WriteRegM == r);
  endfunction

  function automatic logic hazard_m();
    logic lw, br;
    lw = MemtoRegE && (RtE == RsD || RtE == RtD);
    br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    return lw || br;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_m <= -1;
      c16_m <= 0;
      c4_m  <= 0;
    end else if (age_m < 0) begin
      if (hazard_m()) begin
        c16_m <= (c16_m == 65535) ? c16_m : c16_m + 1;
        c4_m  <= (c4_m == 15) ? c4_m : c4_m + 1;
      end
      if (HaltD && !BranchD && !JumpD && !hazard_m()) age_m <= 1;
    end else if (age_m <= DRAIN) begin
      age_m <= age_m + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic hz_c, run_c, stall_c;
  always @(negedge clk) begin
    if (chk_en) begin
      hz_c    = hazard_m();
      run_c   = (age_m < 0);
      stall_c = run_c ? hz_c : 1'b1;
      check("ForwardAE", 32'(ForwardAE), 32'(fwd_e(RsE)));
      check("ForwardBE", 32'(ForwardBE), 32'(fwd_e(RtE)));
      check("ForwardAD", 32'(ForwardAD), 32'(fwd_d(RsD)));
      check("ForwardBD", 32'(ForwardBD), 32'(fwd_d(RtD)));
      check("StallF", 32'(StallF), 32'(stall_c));
      check("StallD", 32'(StallD), 32'(stall_c));
      check("FlushE", 32'(FlushE), 32'(stall_c));
      check("FlushD", 32'(FlushD), 32'(run_c && (PCSrcD || JumpD) && !hz_c));
      check("Draining", 32'(Draining), 32'(age_m >= 1 && age_m <= DRAIN));
      check("Halted", 32'(Halted), 32'(age_m > DRAIN));
      check("StallCount", 32'(StallCount), 32'(c16_m));
      check("StallCount4", 32'(s_StallCount), 32'(c4_m));
      check("s_StallF", 32'(s_StallF), 32'(stall_c));
      check("s_Halted", 32'(s_Halted), 32'(age_m > DRAIN));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0; HaltD = 0;
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    MemtoRegE = 1; RtE = 7; RsD = 7;
  endtask

  task automatic do_reset();
    step();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic random_inputs();
    RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
    BranchD = ($urandom_range(0, 3) == 0); PCSrcD = 1'($urandom_range(0, 1));
    JumpD = ($urandom_range(0, 5) == 0); HaltD = ($urandom_range(0, 24) == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    rst_n = 0;
    step();
    chk_en = 1'b1;
    step();
    // Reset with all inputs low: every output is zero.
    #2;
    check("rst_StallF", 32'(StallF), 0);
    check("rst_FlushD", 32'(FlushD), 0);
    check("rst_ForwardAE", 32'(ForwardAE), 0);
    check("rst_Draining", 32'(Draining), 0);
    check("rst_Halted", 32'(Halted), 0);
    check("rst_StallCount", 32'(StallCount), 0);
    step();
    rst_n = 1;

    // Forwarding priority: M beats W, r0 never forwards.
    step();
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1 check("fwd_prio_M", 32'(ForwardAE), 32'h2);
    RegWriteM = 0;
    #1 check("fwd_W", 32'(ForwardAE), 32'h1);
    RsE = 0;
    #1 check("fwd_r0", 32'(ForwardAE), 32'h0);

    // Load-use stall and counter increment.
    step();
    idle();
    load_use();
    #2;
    check("lu_StallF", 32'(StallF), 1);
    check("lu_StallD", 32'(StallD), 1);
    check("lu_FlushE", 32'(FlushE), 1);
    check("lu_cnt_before", 32'(StallCount), 0);
    step();
    idle();
    #2 check("lu_cnt_after", 32'(StallCount), 1);

    // Branch dependency stalls and suppresses the flush; without it, flush.
    step();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; PCSrcD = 1;
    #2;
    check("br_stall", 32'(StallF), 1);
    check("br_FlushD", 32'(FlushD), 0);
    step();
    WriteRegE = 4;
    #2;
    check("br_nostall", 32'(StallF), 0);
    check("br_flush", 32'(FlushD), 1);

    // Halt concurrent with a load-use stall is deferred one cycle.
    step();
    idle();
    HaltD = 1;
    load_use();
    #2 check("halt_stalled", 32'(Draining), 0);
    step();
    idle();
    HaltD = 1;              // cycle N: qualified
    #2 check("halt_N", 32'(Draining), 0);
    step();
    idle();
    for (int i = 1; i <= DRAIN; i++) begin
      #2;
      check("drain_D", 32'(Draining), 1);
      check("drain_H", 32'(Halted), 0);
      check("drain_StallF", 32'(StallF), 1);
      step();
    end
    load_use();
    PCSrcD = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("halted_H", 32'(Halted), 1);
      check("halted_D", 32'(Draining), 0);
      check("halted_StallF", 32'(StallF), 1);
      check("halted_FlushD", 32'(FlushD), 0);
      check("halted_cnt", 32'(StallCount), 3);
      step();
    end

    // Reset in the middle of a drain, then a fresh full drain.
    do_reset();
    load_use();
    step();
    idle();
    HaltD = 1;              // cycle N
    step();
    HaltD = 0;              // N+1
    step();                 // N+2
    #1;
    check("mid_drain_pre", 32'(Draining), 1);
    rst_n = 0;
    #1;
    check("async_Draining", 32'(Draining), 0);
    check("async_Halted", 32'(Halted), 0);
    check("async_StallCount", 32'(StallCount), 0);
    step();
    rst_n = 1;
    step();
    HaltD = 1;
    step();
    HaltD = 0;
    for (int i = 1; i <= DRAIN; i++) begin
      #2 check("redrain_D", 32'(Draining), 1);
      step();
    end
    #2 check("redrain_H", 32'(Halted), 1);

    // Saturation of the narrow counter after 20 load-use cycles.
    do_reset();
    load_use();
    repeat (20) step();
    idle();
    #2;
    check("sat_cnt4", 32'(s_StallCount), 15);
    check("sat_cnt16", 32'(StallCount), 20);
    step();
    load_use();
    step();
    idle();
    #2 check("sat_hold", 32'(s_StallCount), 15);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step();
      random_inputs();
      rst_n = ($urandom_range(0, 59) != 0);
    end
    step();
    rst_n = 1;
    idle();
    step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4: number of bubble cycles inserted before halting.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-event counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports RsD, RtD  in  5 each  decode-stage source register numbers.
REQ-006 SHALL have ports RsE, RtE  in  5 each  execute-stage source register numbers.
REQ-007 SHALL have ports WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
REQ-008 SHALL have ports RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enable per stage.
REQ-009 SHALL have ports MemtoRegE, MemtoRegM  in  1 each  load in flight in E or M.
REQ-010 SHALL have ports BranchD, PCSrcD, JumpD, HaltD  in  1 each  decode branch, branch taken, jump, halt opcode.
REQ-011 SHALL have ports StallF, StallD  out  1 each  hold PC and IF/ID register.
REQ-012 SHALL have ports FlushD, FlushE  out  1 each  clear IF/ID and ID/EX to a bubble.
REQ-013 SHALL have ports ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 10 M-stage result, 01 W-stage result.
REQ-014 SHALL have ports ForwardAD, ForwardBD  out  1 each  decode comparator operand taken from M-stage result.
REQ-015 SHALL have ports Draining, Halted  out  1 each  FSM status.
REQ-016 SHALL have port StallCount  out  CNT_W  number of hazard stall cycles.

Function
REQ-017 SHALL implement FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-018 SHALL drive ForwardAE=10 when RsE!=0, RegWriteM=1 and WriteRegM==RsE; otherwise 01 when RsE!=0, RegWriteW=1 and WriteRegW==RsE; otherwise 00. The M-stage match has priority. ForwardBE uses the same rule on RtE.
REQ-019 SHALL drive ForwardAD=1 iff RsD!=0, RegWriteM=1 and WriteRegM==RsD; ForwardBD uses the same rule on RtD.
REQ-020 SHALL compute lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
REQ-021 SHALL compute branchstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
REQ-022 SHALL, in RUN, drive StallF=StallD=FlushE=lwstall|branchstall, and FlushD=(PCSrcD|JumpD)&~StallD.
REQ-023 SHALL treat HaltD as qualified only when BranchD=0, JumpD=0 and StallD=0; while HaltD is stalled it SHALL be taken on the first unstalled cycle.
REQ-024 SHALL, on a qualified HaltD in RUN, move to DRAIN on the next edge and load the drain counter with DRAIN_CYCLES-1.
REQ-025 SHALL, in DRAIN, drive StallF=StallD=FlushE=1 and FlushD=0, decrement the counter each cycle, and move to HALTED on the edge where the counter equals 0. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
REQ-026 SHALL, in HALTED, hold StallF=StallD=FlushE=1 and FlushD=0; HALTED SHALL be left only by reset.
REQ-027 SHALL drive Draining=1 iff state is DRAIN and Halted=1 iff state is HALTED; both are decoded from registered state only.
REQ-028 SHALL keep forwarding outputs purely combinational and active in every state.
REQ-029 SHALL increment StallCount by 1 on each edge in RUN where lwstall|branchstall=1, saturate at 2^CNT_W-1, and not count in DRAIN or HALTED.
REQ-030 SHALL treat register 0 as never hazarding for forwarding; stall equations compare raw numbers, so conservative stalls on r0 are permitted.

Reset
REQ-031 SHALL, while rst_n=0, force state RUN, drain counter 0 and StallCount 0 immediately, independent of clk.
REQ-032 SHALL, with rst_n=0 and all inputs 0, present every output as 0.
REQ-033 SHALL, when reset is asserted in DRAIN or HALTED, return to RUN with Draining=Halted=0 before the next edge.

Verification
REQ-034 SHALL cover forwarding priority: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> 01; with RsE=0 -> 00.
REQ-035 SHALL cover load-use: MemtoRegE=1, RtE=7, RsD=7 -> StallF=StallD=FlushE=1 for that cycle and StallCount increments 0->1.
REQ-036 SHALL cover branch: BranchD=1, RegWriteE=1, WriteRegE=3, RtD=3, PCSrcD=1 -> stall, FlushD=0; with the hazard removed -> FlushD=1, no stall.
REQ-037 SHALL cover halt: a qualified HaltD at cycle N -> Draining=1 for cycles N+1..N+4, then Halted=1 from N+5 onward with StallF=1; HaltD concurrent with lwstall delays DRAIN entry by one cycle.
REQ-038 SHALL cover reset mid-DRAIN: rst_n low at cycle N+2 -> Draining=0 and StallCount=0 asynchronously, and the next HaltD restarts a full 4-cycle drain.
REQ-039 SHALL cover saturation: with CNT_W=4 and 20 consecutive load-use cycles -> StallCount=15 held.
